// File: rtl/alu_seq16.sv
// alu_seq16: drives the 8-bit ALU to build SM83 16-bit arithmetic.
// It runs two chained byte passes (low, then high) and assembles the
// 16-bit result, the flag values and the flag write mask.
module alu_seq16 #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        abort,
  output logic        busy,
  output logic        alu_req,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hout,
  input  logic        alu_ack,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  flags_we,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [1:0] OP_ADD16  = 2'd0;
  localparam logic [1:0] OP_INC16  = 2'd1;
  localparam logic [1:0] OP_DEC16  = 2'd2;
  localparam logic [1:0] OP_ADDSPE = 2'd3;

  // The last request cycle of a phase before it is abandoned.
  localparam logic [15:0] TMO_LAST = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic        c_lo_q, c_lo_d;
  logic        h_lo_q, h_lo_d;
  logic [7:0]  res_hi_q, res_hi_d;
  logic        c_hi_q, c_hi_d;
  logic        h_hi_q, h_hi_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  flags_we_q, flags_we_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_hit;

  // Timeout fires only when enabled and the phase has used its last cycle.
  always_comb begin
    tmo_hit = (ACK_TIMEOUT > 0) && (cnt_q == TMO_LAST);
  end

  // Next-state, datapath capture and output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_lo_d   = res_lo_q;
    c_lo_d     = c_lo_q;
    h_lo_d     = h_lo_q;
    res_hi_d   = res_hi_q;
    c_hi_d     = c_hi_q;
    h_hi_d     = h_hi_q;
    result_d   = result_q;
    flags_d    = flags_q;
    flags_we_d = flags_we_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    alu_req    = 1'b0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_cin    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          op_d    = op;
          opa_d   = opa;
          opb_d   = opb;
          state_d = LO;
        end
      end

      LO: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_a   = opa_q[7:0];
        case (op_q)
          OP_INC16: alu_b = 8'h00;
          OP_DEC16: alu_b = 8'hFF;
          default:  alu_b = opb_q[7:0];
        endcase
        alu_cin = (op_q == OP_INC16);
        if (abort) begin
          state_d = IDLE;
        end else if (alu_ack) begin
          res_lo_d = alu_res;
          c_lo_d   = alu_cout;
          h_lo_d   = alu_hout;
          state_d  = HI;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end

      HI: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_a   = opa_q[15:8];
        case (op_q)
          OP_INC16:  alu_b = 8'h00;
          OP_DEC16:  alu_b = 8'hFF;
          OP_ADDSPE: alu_b = {8{opb_q[7]}};
          default:   alu_b = opb_q[15:8];
        endcase
        alu_cin = c_lo_q;
        if (abort) begin
          state_d = IDLE;
        end else if (alu_ack) begin
          res_hi_d = alu_res;
          c_hi_d   = alu_cout;
          h_hi_d   = alu_hout;
          state_d  = DONE;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end

      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
        if (!abort) begin
          done     = 1'b1;
          result_d = {res_hi_q, res_lo_q};
          case (op_q)
            OP_ADD16: begin
              flags_d    = {1'b0, 1'b0, h_hi_q, c_hi_q};
              flags_we_d = 4'b0111;
            end
            OP_ADDSPE: begin
              flags_d    = {1'b0, 1'b0, h_lo_q, c_lo_q};
              flags_we_d = 4'b1111;
            end
            default: begin
              flags_d    = 4'b0000;
              flags_we_d = 4'b0000;
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (state_q == LO || state_q == HI) begin
      cnt_d = cnt_q + 16'd1;
    end

    result   = result_d;
    flags    = flags_d;
    flags_we = flags_we_d;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      opa_q      <= 16'h0000;
      opb_q      <= 16'h0000;
      res_lo_q   <= 8'h00;
      c_lo_q     <= 1'b0;
      h_lo_q     <= 1'b0;
      res_hi_q   <= 8'h00;
      c_hi_q     <= 1'b0;
      h_hi_q     <= 1'b0;
      result_q   <= 16'h0000;
      flags_q    <= 4'b0000;
      flags_we_q <= 4'b0000;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_lo_q   <= res_lo_d;
      c_lo_q     <= c_lo_d;
      h_lo_q     <= h_lo_d;
      res_hi_q   <= res_hi_d;
      c_hi_q     <= c_hi_d;
      h_hi_q     <= h_hi_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      flags_we_q <= flags_we_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
